lsu_split_stage: RTL and testbench



---
 rtl/lsu_split_stage.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_lsu_split_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_split_stage.sv
// Memory stage between execute and writeback: drives the OBI data port, splits
// line-crossing accesses into two beats and aligns/extends the returned load data.
module lsu_split_stage #(
    parameter int XLEN             = 64,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                squash_i,
    input  logic                stall_i,
    input  logic                valid_i,
    input  logic [XLEN-1:0]     addr_i,
    input  logic [XLEN-1:0]     wdata_i,
    input  logic [3:0]          width_1h_i,
    input  logic                rd_i,
    input  logic                wr_i,
    input  logic                sign_i,
    input  logic [4:0]          rd_idx_i,
    input  logic                rd_wr_en_i,
    output logic                stall_o,
    output logic                illegal_o,
    output logic                dmem_req_o,
    input  logic                dmem_gnt_i,
    output logic [XLEN-1:0]     dmem_addr_o,
    output logic                dmem_we_o,
    output logic [XLEN/8-1:0]   dmem_be_o,
    output logic [XLEN-1:0]     dmem_wdata_o,
    input  logic                dmem_rvalid_i,
    input  logic [XLEN-1:0]     dmem_rdata_i,
    output logic                valid_o,
    output logic                fault_o,
    output logic [XLEN-1:0]     rd_data_o,
    output logic [4:0]          rd_idx_o,
    output logic                rd_wr_en_o
);
    localparam int BYTES = XLEN / 8;
    localparam int OB    = $clog2(BYTES);
    localparam int MW    = 2 * BYTES;
    localparam logic [MW-1:0]   MASK_ONE  = {{(MW-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ADDR_STEP = XLEN'(BYTES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ_LO  = 3'd1,
        S_WAIT_LO = 3'd2,
        S_REQ_HI  = 3'd3,
        S_WAIT_HI = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    function automatic logic [3:0] width_bytes(input logic [3:0] w1h);
        logic [3:0] n;
        case (w1h)
            4'b0001: n = 4'd1;
            4'b0010: n = 4'd2;
            4'b0100: n = 4'd4;
            4'b1000: n = 4'd8;
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    function automatic logic [MW-1:0] lane_mask(input logic [OB-1:0] off, input logic [3:0] n);
        logic [MW-1:0] base;
        base = (MASK_ONE << n) - MASK_ONE;
        return base << off;
    endfunction

    // Byte i of the store data lands on lane (i + off) mod BYTES in both beats.
    function automatic logic [XLEN-1:0] rotate_bytes(input logic [XLEN-1:0] d, input logic [OB-1:0] off);
        logic [XLEN-1:0] r;
        logic [OB-1:0]   j;
        r = '0;
        for (int i = 0; i < BYTES; i++) begin
            j = OB'(i) + off;
            r[8*j +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] lo, input logic [XLEN-1:0] hi,
                                                    input logic [OB-1:0] off, input logic [3:0] n,
                                                    input logic sgn);
        logic [2*XLEN-1:0] cat;
        logic [XLEN-1:0]   raw;
        logic [XLEN-1:0]   res;
        logic              sbit;
        cat = {hi, lo} >> {off, 3'b000};
        raw = cat[XLEN-1:0];
        case (n)
            4'd1:    sbit = raw[7];
            4'd2:    sbit = raw[15];
            4'd4:    sbit = raw[31];
            default: sbit = raw[XLEN-1];
        endcase
        sbit = sbit & sgn;
        for (int b = 0; b < BYTES; b++) begin
            res[8*b +: 8] = (b < int'(n)) ? raw[8*b +: 8] : {8{sbit}};
        end
        return res;
    endfunction

    state_t            r_state;
    logic [OB-1:0]     r_off;
    logic [3:0]        r_nbytes;
    logic              r_sign;
    logic              r_is_load;
    logic              r_cross;
    logic [4:0]        r_rd_idx;
    logic              r_rd_wr_en;
    logic [BYTES-1:0]  r_be_hi;
    logic [XLEN-1:0]   r_rdata_lo;
    logic [XLEN-1:0]   r_rdata_hi;
    logic              r_dmem_req;
    logic [XLEN-1:0]   r_dmem_addr;
    logic              r_dmem_we;
    logic [BYTES-1:0]  r_dmem_be;
    logic [XLEN-1:0]   r_dmem_wdata;
    logic              r_valid_o;
    logic              r_fault_o;
    logic [XLEN-1:0]   r_rd_data_o;
    logic [4:0]        r_rd_idx_o;
    logic              r_rd_wr_en_o;

    logic [OB-1:0]     w_off;
    logic [3:0]        w_nbytes;
    logic [4:0]        w_end;
    logic              w_cross;
    logic              w_mem;
    logic              w_illegal;
    logic [MW-1:0]     w_mask;
    logic              w_out_free;
    logic              w_take;
    logic              w_finish;
    logic [XLEN-1:0]   w_lo_src;
    logic [XLEN-1:0]   w_hi_src;
    logic [XLEN-1:0]   w_load_data;

    // Decode of the presented instruction and merge of the captured load's data.
    always_comb begin
        w_off      = addr_i[OB-1:0];
        w_nbytes   = width_bytes(width_1h_i);
        w_end      = 5'(w_off) + 5'(w_nbytes);
        w_cross    = (w_end > 5'(BYTES));
        w_mem      = rd_i | wr_i;
        w_illegal  = w_mem & ((w_nbytes == 4'd0)
                            | ((w_nbytes == 4'd8) & (XLEN == 32))
                            | (w_cross & ~ALLOW_MISALIGNED));
        w_mask     = lane_mask(w_off, w_nbytes);
        w_out_free = ~(r_valid_o & stall_i);
        w_take     = valid_i & ~squash_i & w_out_free & (r_state == S_IDLE);
        w_finish   = w_out_free & (((r_state == S_WAIT_LO) & dmem_rvalid_i & ~r_cross)
                                 | ((r_state == S_WAIT_HI) & dmem_rvalid_i)
                                 | (r_state == S_HOLD));
        // Bypass the response straight into the merge so an aligned access costs no HOLD cycle.
        w_lo_src   = (r_state == S_WAIT_LO) ? dmem_rdata_i : r_rdata_lo;
        w_hi_src   = (r_state == S_WAIT_HI) ? dmem_rdata_i : r_rdata_hi;
        w_load_data = r_is_load ? load_extend(w_lo_src, w_hi_src, r_off, r_nbytes, r_sign) : '0;
    end

    assign illegal_o = valid_i & ~squash_i & w_illegal & (r_state == S_IDLE);
    assign stall_o   = (r_state != S_IDLE) | (r_valid_o & stall_i);

    // Access sequencer and OBI request registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_off        <= '0;
            r_nbytes     <= 4'd0;
            r_sign       <= 1'b0;
            r_is_load    <= 1'b0;
            r_cross      <= 1'b0;
            r_rd_idx     <= 5'd0;
            r_rd_wr_en   <= 1'b0;
            r_be_hi      <= '0;
            r_rdata_lo   <= '0;
            r_rdata_hi   <= '0;
            r_dmem_req   <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_we    <= 1'b0;
            r_dmem_be    <= '0;
            r_dmem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take & w_mem & ~w_illegal) begin
                        r_state      <= S_REQ_LO;
                        r_off        <= w_off;
                        r_nbytes     <= w_nbytes;
                        r_sign       <= sign_i;
                        r_is_load    <= rd_i;
                        r_cross      <= w_cross;
                        r_rd_idx     <= rd_idx_i;
                        r_rd_wr_en   <= rd_wr_en_i;
                        r_be_hi      <= w_mask[MW-1:BYTES];
                        r_rdata_hi   <= '0;
                        r_dmem_req   <= 1'b1;
                        r_dmem_addr  <= {addr_i[XLEN-1:OB], {OB{1'b0}}};
                        r_dmem_we    <= wr_i;
                        r_dmem_be    <= w_mask[BYTES-1:0];
                        r_dmem_wdata <= rotate_bytes(wdata_i, w_off);
                    end
                end
                S_REQ_LO, S_REQ_HI: begin
                    if (dmem_gnt_i) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_dmem_be  <= '0;
                        r_state    <= (r_state == S_REQ_LO) ? S_WAIT_LO : S_WAIT_HI;
                    end
                end
                S_WAIT_LO: begin
                    if (dmem_rvalid_i) begin
                        r_rdata_lo <= dmem_rdata_i;
                        if (r_cross) begin
                            r_state     <= S_REQ_HI;
                            r_dmem_req  <= 1'b1;
                            r_dmem_addr <= r_dmem_addr + ADDR_STEP;
                            r_dmem_we   <= ~r_is_load;
                            r_dmem_be   <= r_be_hi;
                        end else begin
                            r_state <= w_out_free ? S_IDLE : S_HOLD;
                        end
                    end
                end
                S_WAIT_HI: begin
                    if (dmem_rvalid_i) begin
                        r_rdata_hi <= dmem_rdata_i;
                        r_state    <= w_out_free ? S_IDLE : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_out_free) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Writeback output register; holds while downstream stalls a valid result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_o    <= 1'b0;
            r_fault_o    <= 1'b0;
            r_rd_data_o  <= '0;
            r_rd_idx_o   <= 5'd0;
            r_rd_wr_en_o <= 1'b0;
        end else if (w_take & ~w_mem) begin
            r_valid_o    <= 1'b1;
            r_fault_o    <= 1'b0;
            r_rd_data_o  <= '0;
            r_rd_idx_o   <= rd_idx_i;
            r_rd_wr_en_o <= rd_wr_en_i;
        end else if (w_take & w_illegal) begin
            r_valid_o    <= 1'b1;
            r_fault_o    <= 1'b1;
            r_rd_data_o  <= '0;
            r_rd_idx_o   <= rd_idx_i;
            r_rd_wr_en_o <= 1'b0;
        end else if (w_finish) begin
            r_valid_o    <= 1'b1;
            r_fault_o    <= 1'b0;
            r_rd_data_o  <= w_load_data;
            r_rd_idx_o   <= r_rd_idx;
            r_rd_wr_en_o <= r_rd_wr_en;
        end else if (w_out_free) begin
            r_valid_o    <= 1'b0;
        end
    end

    assign dmem_req_o   = r_dmem_req;
    assign dmem_addr_o  = r_dmem_addr;
    assign dmem_we_o    = r_dmem_we;
    assign dmem_be_o    = r_dmem_be;
    assign dmem_wdata_o = r_dmem_wdata;
    assign valid_o      = r_valid_o;
    assign fault_o      = r_fault_o;
    assign rd_data_o    = r_rd_data_o;
    assign rd_idx_o     = r_rd_idx_o;
    assign rd_wr_en_o   = r_rd_wr_en_o;

endmodule

// File: tb/tb_lsu_split_stage.sv
// Scoreboard bench for lsu_split_stage: three instances (64-bit split, 32-bit split,
// 64-bit with misaligned accesses disallowed) share stimulus and one OBI responder.
module tb_lsu_split_stage;
    typedef struct {
        logic        fault;
        logic [63:0] data;
        logic [4:0]  idx;
        logic        wen;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, squash_i, stall_i, rd, wr, sgn, wen, gnt, rvalid;
    logic        valid_a, valid_b, valid_c;
    logic [63:0] addr, wdata, rdata;
    logic [3:0]  width;
    logic [4:0]  idx;

    logic        stall_a, ill_a, req_a, we_a, vo_a, fo_a, weno_a;
    logic [63:0] addr_a, wd_a, rdo_a;
    logic [7:0]  be_a;
    logic [4:0]  idxo_a;
    logic        stall_b, ill_b, req_b, we_b, vo_b, fo_b, weno_b;
    logic [31:0] addr_b, wd_b, rdo_b;
    logic [3:0]  be_b;
    logic [4:0]  idxo_b;
    logic        stall_c, ill_c, req_c, we_c, vo_c, fo_c, weno_c;
    logic [63:0] addr_c, wd_c, rdo_c;
    logic [7:0]  be_c;
    logic [4:0]  idxo_c;

    int n_checks = 0;
    int n_errs   = 0;
    int sel      = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    lsu_split_stage #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) u_a (
        .clk_i(clk), .rst_i(rst_i), .squash_i(squash_i), .stall_i(stall_i), .valid_i(valid_a),
        .addr_i(addr), .wdata_i(wdata), .width_1h_i(width), .rd_i(rd), .wr_i(wr), .sign_i(sgn),
        .rd_idx_i(idx), .rd_wr_en_i(wen), .stall_o(stall_a), .illegal_o(ill_a),
        .dmem_req_o(req_a), .dmem_gnt_i(gnt), .dmem_addr_o(addr_a), .dmem_we_o(we_a),
        .dmem_be_o(be_a), .dmem_wdata_o(wd_a), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
        .valid_o(vo_a), .fault_o(fo_a), .rd_data_o(rdo_a), .rd_idx_o(idxo_a), .rd_wr_en_o(weno_a));

    lsu_split_stage #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) u_b (
        .clk_i(clk), .rst_i(rst_i), .squash_i(squash_i), .stall_i(stall_i), .valid_i(valid_b),
        .addr_i(addr[31:0]), .wdata_i(wdata[31:0]), .width_1h_i(width), .rd_i(rd), .wr_i(wr),
        .sign_i(sgn), .rd_idx_i(idx), .rd_wr_en_i(wen), .stall_o(stall_b), .illegal_o(ill_b),
        .dmem_req_o(req_b), .dmem_gnt_i(gnt), .dmem_addr_o(addr_b), .dmem_we_o(we_b),
        .dmem_be_o(be_b), .dmem_wdata_o(wd_b), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata[31:0]),
        .valid_o(vo_b), .fault_o(fo_b), .rd_data_o(rdo_b), .rd_idx_o(idxo_b), .rd_wr_en_o(weno_b));

    lsu_split_stage #(.XLEN(64), .ALLOW_MISALIGNED(1'b0)) u_c (
        .clk_i(clk), .rst_i(rst_i), .squash_i(squash_i), .stall_i(stall_i), .valid_i(valid_c),
        .addr_i(addr), .wdata_i(wdata), .width_1h_i(width), .rd_i(rd), .wr_i(wr), .sign_i(sgn),
        .rd_idx_i(idx), .rd_wr_en_i(wen), .stall_o(stall_c), .illegal_o(ill_c),
        .dmem_req_o(req_c), .dmem_gnt_i(gnt), .dmem_addr_o(addr_c), .dmem_we_o(we_c),
        .dmem_be_o(be_c), .dmem_wdata_o(wd_c), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
        .valid_o(vo_c), .fault_o(fo_c), .rd_data_o(rdo_c), .rd_idx_o(idxo_c), .rd_wr_en_o(weno_c));

    logic        s_req, s_we, s_stall, s_ill, s_vo;
    logic [63:0] s_addr, s_wd, s_rdo;
    logic [7:0]  s_be;

    // View of whichever instance the current test is driving.
    always_comb begin
        s_req = req_a; s_we = we_a; s_stall = stall_a; s_ill = ill_a; s_vo = vo_a;
        s_addr = addr_a; s_wd = wd_a; s_rdo = rdo_a; s_be = be_a;
        case (sel)
            1: begin
                s_req = req_b; s_we = we_b; s_stall = stall_b; s_ill = ill_b; s_vo = vo_b;
                s_addr = 64'(addr_b); s_wd = 64'(wd_b); s_rdo = 64'(rdo_b); s_be = 8'(be_b);
            end
            2: begin
                s_req = req_c; s_we = we_c; s_stall = stall_c; s_ill = ill_c; s_vo = vo_c;
                s_addr = addr_c; s_wd = wd_c; s_rdo = rdo_c; s_be = be_c;
            end
            default: ;
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%h, want 0x%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input int inst, input logic f, input logic [63:0] d,
                              input logic [4:0] ix, input logic w);
        exp_t e;
        e.fault = f; e.data = d; e.idx = ix; e.wen = w;
        case (inst)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic pop_cmp(input int inst, input logic f, input logic [63:0] d,
                           input logic [4:0] ix, input logic w);
        exp_t e;
        logic got;
        got = 1'b0;
        case (inst)
            0:       if (q_a.size() > 0) begin e = q_a.pop_front(); got = 1'b1; end
            1:       if (q_b.size() > 0) begin e = q_b.pop_front(); got = 1'b1; end
            default: if (q_c.size() > 0) begin e = q_c.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
            n_checks++;
            n_errs++;
            $display("FAIL unexpected_result: inst %0d presented data 0x%h, want no result", inst, d);
        end else begin
            chk("res_fault", 64'(f), 64'(e.fault));
            chk("res_data", d, e.data);
            chk("res_idx", 64'(ix), 64'(e.idx));
            chk("res_wen", 64'(w), 64'(e.wen));
        end
    endtask

    // Scoreboard monitor: one pop per result handed to writeback.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (vo_a && !stall_i) pop_cmp(0, fo_a, rdo_a, idxo_a, weno_a);
            if (vo_b && !stall_i) pop_cmp(1, fo_b, 64'(rdo_b), idxo_b, weno_b);
            if (vo_c && !stall_i) pop_cmp(2, fo_c, rdo_c, idxo_c, weno_c);
        end
    end

    task automatic issue(input int inst, input logic [63:0] a, input logic [63:0] wd,
                         input logic [3:0] w1h, input logic r, input logic w, input logic sg,
                         input logic [4:0] ix, input logic we_en, input logic e_ill);
        sel = inst; addr = a; wdata = wd; width = w1h; rd = r; wr = w; sgn = sg;
        idx = ix; wen = we_en;
        valid_a = (inst == 0); valid_b = (inst == 1); valid_c = (inst == 2);
        @(negedge clk);
        chk("illegal_o", 64'(s_ill), 64'(e_ill));
        chk("req_at_issue", 64'(s_req), 64'd0);
        step();
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    endtask

    task automatic beat(input string nm, input int gdly, input logic [63:0] e_addr,
                        input logic [7:0] e_be, input logic e_we, input logic [63:0] e_wd,
                        input logic chk_wd, input logic [63:0] rdat);
        for (int k = 0; k < gdly; k++) begin
            @(negedge clk);
            chk({nm, "_req_wait"}, 64'(s_req), 64'd1);
            chk({nm, "_addr_wait"}, s_addr, e_addr);
            chk({nm, "_be_wait"}, 64'(s_be), 64'(e_be));
            chk({nm, "_stall_wait"}, 64'(s_stall), 64'd1);
            step();
        end
        gnt = 1'b1;
        @(negedge clk);
        chk({nm, "_req"}, 64'(s_req), 64'd1);
        chk({nm, "_addr"}, s_addr, e_addr);
        chk({nm, "_be"}, 64'(s_be), 64'(e_be));
        chk({nm, "_we"}, 64'(s_we), 64'(e_we));
        chk({nm, "_stall_req"}, 64'(s_stall), 64'd1);
        if (chk_wd) chk({nm, "_wdata"}, s_wd, e_wd);
        step();
        gnt = 1'b0; rvalid = 1'b1; rdata = rdat;
        @(negedge clk);
        chk({nm, "_req_after_gnt"}, 64'(s_req), 64'd0);
        chk({nm, "_stall_wait_rsp"}, 64'(s_stall), 64'd1);
        step();
        rvalid = 1'b0; rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; squash_i = 1'b0; stall_i = 1'b0; rd = 1'b0; wr = 1'b0; sgn = 1'b0;
        wen = 1'b0; gnt = 1'b0; rvalid = 1'b0; valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        addr = '0; wdata = '0; rdata = '0; width = 4'd0; idx = 5'd0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_req_a", 64'(req_a), 64'd0);
        chk("rst_be_a", 64'(be_a), 64'd0);
        chk("rst_valid_a", 64'(vo_a), 64'd0);
        chk("rst_fault_a", 64'(fo_a), 64'd0);
        chk("rst_req_b", 64'(req_b), 64'd0);
        chk("rst_valid_c", 64'(vo_c), 64'd0);
        step();
        rst_i = 1'b0;
        step();

        // Aligned ld, best-case latency
        expect_res(0, 1'b0, 64'h1122334455667788, 5'd5, 1'b1);
        issue(0, 64'h1000, 64'd0, 4'b1000, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        beat("ld_al", 0, 64'h1000, 8'hFF, 1'b0, 64'd0, 1'b0, 64'h1122334455667788);
        @(negedge clk);
        chk("ld_al_valid_c3", 64'(s_vo), 64'd1);
        chk("ld_al_stall_c3", 64'(s_stall), 64'd0);
        step();

        // Signed lw split across two lines
        expect_res(0, 1'b0, 64'hFFFFFFFF_CCDDAABB, 5'd7, 1'b1);
        issue(0, 64'h2006, 64'd0, 4'b0100, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
        beat("lw_lo", 0, 64'h2000, 8'hC0, 1'b0, 64'd0, 1'b0, 64'hAABB_0000_0000_0000);
        beat("lw_hi", 0, 64'h2008, 8'h03, 1'b0, 64'd0, 1'b0, 64'h0000_0000_0000_CCDD);
        @(negedge clk);
        chk("lw_split_valid", 64'(s_vo), 64'd1);
        step();

        // 32-bit split sh, rotated store data
        expect_res(1, 1'b0, 64'd0, 5'd0, 1'b0);
        issue(1, 64'h103, 64'hBEEF, 4'b0010, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        beat("sh_lo", 0, 64'h100, 8'h08, 1'b1, 64'hEF0000BE, 1'b1, 64'd0);
        beat("sh_hi", 0, 64'h104, 8'h01, 1'b1, 64'hEF0000BE, 1'b1, 64'd0);
        step();

        // Grant withheld 3 cycles, then downstream stall for 2 cycles
        expect_res(0, 1'b0, 64'h89AB, 5'd9, 1'b1);
        issue(0, 64'h3002, 64'd0, 4'b0010, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
        stall_i = 1'b1;
        beat("lh_gnt3", 3, 64'h3000, 8'h0C, 1'b0, 64'd0, 1'b0, 64'h0123456789ABCDEF);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("hold_valid", 64'(s_vo), 64'd1);
            chk("hold_data", s_rdo, 64'h89AB);
            chk("hold_stall_o", 64'(s_stall), 64'd1);
            step();
        end
        stall_i = 1'b0;
        step();

        // Non-memory op passes through in one cycle
        expect_res(0, 1'b0, 64'd0, 5'd12, 1'b1);
        issue(0, 64'h55, 64'h77, 4'b1000, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0);
        step();

        // Squashed load: no request, no result
        squash_i = 1'b1;
        issue(0, 64'h6000, 64'd0, 4'b1000, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0);
        squash_i = 1'b0;
        @(negedge clk);
        chk("squash_no_req", 64'(s_req), 64'd0);
        chk("squash_no_valid", 64'(s_vo), 64'd0);
        step();

        // Misaligned lw with misaligned disallowed, and double on 32-bit
        expect_res(2, 1'b1, 64'd0, 5'd3, 1'b0);
        issue(2, 64'h7, 64'd0, 4'b0100, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
        @(negedge clk);
        chk("ill_c_no_req", 64'(s_req), 64'd0);
        chk("ill_c_valid", 64'(s_vo), 64'd1);
        step();
        expect_res(1, 1'b1, 64'd0, 5'd4, 1'b0);
        issue(1, 64'h10, 64'd0, 4'b1000, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1);
        @(negedge clk);
        chk("ill_b_no_req", 64'(s_req), 64'd0);
        step();

        // Reset during WAIT_HI, then a stray response
        issue(0, 64'h2006, 64'd0, 4'b0100, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        beat("rst_lo", 0, 64'h2000, 8'hC0, 1'b0, 64'd0, 1'b0, 64'h1111_2222_3333_4444);
        gnt = 1'b1;
        @(negedge clk);
        chk("rst_hi_addr", s_addr, 64'h2008);
        step();
        gnt = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_wait_hi_stall", 64'(s_stall), 64'd1);
        step();
        rst_i = 1'b0;
        rvalid = 1'b1; rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        @(negedge clk);
        chk("rst_idle_req", 64'(s_req), 64'd0);
        chk("rst_idle_stall", 64'(s_stall), 64'd0);
        step();
        rvalid = 1'b0; rdata = '0;
        @(negedge clk);
        chk("stray_rvalid_no_valid", 64'(s_vo), 64'd0);
        step();
        expect_res(0, 1'b0, 64'h0F0E0D0C0B0A0908, 5'd2, 1'b1);
        issue(0, 64'h5000, 64'd0, 4'b1000, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0);
        beat("ld_after_rst", 0, 64'h5000, 8'hFF, 1'b0, 64'd0, 1'b0, 64'h0F0E0D0C0B0A0908);
        step();
        step();

        chk("queue_a_drained", 64'(q_a.size()), 64'd0);
        chk("queue_b_drained", 64'(q_b.size()), 64'd0);
        chk("queue_c_drained", 64'(q_c.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
